// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D cache block-fill arbiter: state encodings, bus widths, block geometry.
// Latency: none (definitions only); backpressure: not applicable.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      I_FILL  = 2'd1,
      D_FILL  = 2'd2,
      D_WRITE = 2'd3
   } arbState_t;

   localparam int ADDR_W      = 16;
   localparam int DATA_W      = 16;
   localparam int DEF_WORDS   = 8;
   localparam int DEF_LATENCY = 4;

   // Byte-address bits below the block number: word index plus the byte-in-word bit.
   function automatic int blkOffW(input int words);
      return $clog2(words) + 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_fill_counter.sv
// Word index counter for fill issue/return; counts 0..WORDS and holds there until cleared.
// Latency: 1 cycle from inc to count; backpressure: none, inc is ignored once WORDS is reached.
module fill_counter #(
   parameter int WORDS = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   inc,
   output logic [$clog2(WORDS):0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !count[$clog2(WORDS)]) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter of I-fill, D-fill and D-write-through onto one memory port.
// Latency: fill done WORDS+LATENCY cycles after grant, write acked 1 cycle after grant; losers stall via *_busy.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int LATENCY = DEF_LATENCY,
   parameter int WORDS   = DEF_WORDS
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_miss_req,
   input  logic [ADDR_W-1:0]          i_miss_addr,
   input  logic                       d_miss_req,
   input  logic [ADDR_W-1:0]          d_miss_addr,
   input  logic                       d_wr_req,
   input  logic [ADDR_W-1:0]          d_wr_addr,
   input  logic [DATA_W-1:0]          d_wr_data,
   output logic                       i_busy,
   output logic                       d_busy,
   output logic                       i_fill_we,
   output logic                       d_fill_we,
   output logic                       i_fill_done,
   output logic                       d_fill_done,
   output logic                       d_wr_ack,
   output logic [DATA_W-1:0]          fill_data,
   output logic [$clog2(WORDS)-1:0]   fill_word,
   output logic                       mem_en,
   output logic                       mem_wr,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   input  logic [DATA_W-1:0]          mem_rdata,
   input  logic                       mem_rvalid
);

   localparam int IDX_W = $clog2(WORDS);
   localparam int OFF_W = blkOffW(WORDS);
   localparam int BLK_W = ADDR_W - OFF_W;
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

   if (LATENCY < 1 || LATENCY > 7) begin : gBadLatency
      $error("mem_arbiter: LATENCY must be 1..7");
   end
   if (WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : gBadWords
      $error("mem_arbiter: WORDS must be a power of two >= 2");
   end

   arbState_t        state, nextState;
   logic [BLK_W-1:0] blkAddr;
   logic [CNT_W-1:0] issueCnt, retCnt;
   logic             inFill, issueEn, retEn, fillLast, cntClr;
   logic             unusedAddrBits;

   assign unusedAddrBits = &{1'b0, i_miss_addr[OFF_W-1:0], d_miss_addr[OFF_W-1:0]};

   assign inFill   = (state == I_FILL) || (state == D_FILL);
   assign issueEn  = inFill && !issueCnt[IDX_W];
   assign retEn    = inFill && mem_rvalid;
   assign fillLast = retEn && (retCnt == CNT_LAST);
   assign cntClr   = (state == IDLE);

   fill_counter #(.WORDS(WORDS)) uIssueCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cntClr),
      .inc   (issueEn),
      .count (issueCnt)
   );

   fill_counter #(.WORDS(WORDS)) uRetCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cntClr),
      .inc   (retEn),
      .count (retCnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: begin
            if (d_wr_req)        nextState = D_WRITE;
            else if (d_miss_req) nextState = D_FILL;
            else if (i_miss_req) nextState = I_FILL;
         end
         I_FILL, D_FILL: if (fillLast) nextState = IDLE;
         D_WRITE:        nextState = IDLE;
         default:        nextState = IDLE;
      endcase
   end

   // Block number is captured only on the grant edge; the requester may move its address afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blkAddr <= '0;
      end else if (state == IDLE) begin
         if (nextState == D_FILL)      blkAddr <= d_miss_addr[ADDR_W-1:OFF_W];
         else if (nextState == I_FILL) blkAddr <= i_miss_addr[ADDR_W-1:OFF_W];
      end
   end

   // Every output is gated by rst_n so reset silences the port immediately, not at the next edge.
   always_comb begin
      i_busy      = 1'b0;
      d_busy      = 1'b0;
      i_fill_we   = 1'b0;
      d_fill_we   = 1'b0;
      i_fill_done = 1'b0;
      d_fill_done = 1'b0;
      d_wr_ack    = 1'b0;
      fill_data   = '0;
      fill_word   = '0;
      mem_en      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      if (rst_n) begin
         unique case (state)
            I_FILL, D_FILL: begin
               if (issueEn) begin
                  mem_en   = 1'b1;
                  mem_addr = {blkAddr, issueCnt[IDX_W-1:0], 1'b0};
               end
               if (retEn) begin
                  fill_data = mem_rdata;
                  fill_word = retCnt[IDX_W-1:0];
                  if (state == I_FILL) begin
                     i_fill_we   = 1'b1;
                     i_fill_done = fillLast;
                  end else begin
                     d_fill_we   = 1'b1;
                     d_fill_done = fillLast;
                  end
               end
            end
            D_WRITE: begin
               mem_en    = 1'b1;
               mem_wr    = 1'b1;
               mem_addr  = d_wr_addr;
               mem_wdata = d_wr_data;
               d_wr_ack  = 1'b1;
            end
            default: ;
         endcase
         i_busy = i_miss_req & ~i_fill_done;
         d_busy = (d_miss_req & ~d_fill_done) | (d_wr_req & ~d_wr_ack);
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model; data returned is addr ^ 16'hA5A5.
module tb_mem_arbiter;

   localparam int LAT   = 4;
   localparam int WORDS = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_miss_req, d_miss_req, d_wr_req;
   logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
   logic        i_busy, d_busy, i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack;
   logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  fill_word;
   logic        mem_en, mem_wr, mem_rvalid;
   logic        spur;

   int nChecks = 0;
   int nFails  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.LATENCY(LAT), .WORDS(WORDS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_miss_req  (i_miss_req),
      .i_miss_addr (i_miss_addr),
      .d_miss_req  (d_miss_req),
      .d_miss_addr (d_miss_addr),
      .d_wr_req    (d_wr_req),
      .d_wr_addr   (d_wr_addr),
      .d_wr_data   (d_wr_data),
      .i_busy      (i_busy),
      .d_busy      (d_busy),
      .i_fill_we   (i_fill_we),
      .d_fill_we   (d_fill_we),
      .i_fill_done (i_fill_done),
      .d_fill_done (d_fill_done),
      .d_wr_ack    (d_wr_ack),
      .fill_data   (fill_data),
      .fill_word   (fill_word),
      .mem_en      (mem_en),
      .mem_wr      (mem_wr),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_rvalid  (mem_rvalid)
   );

   // Memory model: reads come back exactly LAT cycles after mem_en, flushed by reset.
   logic [15:0] pipeAddr [LAT];
   logic        pipeVld  [LAT];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) begin
            pipeVld[i]  <= 1'b0;
            pipeAddr[i] <= '0;
         end
      end else begin
         pipeVld[0]  <= mem_en && !mem_wr;
         pipeAddr[0] <= mem_addr;
         for (int i = 1; i < LAT; i++) begin
            pipeVld[i]  <= pipeVld[i-1];
            pipeAddr[i] <= pipeAddr[i-1];
         end
      end
   end

   assign mem_rvalid = pipeVld[LAT-1] | spur;
   assign mem_rdata  = spur ? 16'hDEAD : (pipeAddr[LAT-1] ^ 16'hA5A5);

   logic [59:0] allOuts;
   assign allOuts = {i_busy, d_busy, i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack,
                     mem_en, mem_wr, fill_data, fill_word, mem_addr, mem_wdata};

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Entered post-edge in an IDLE cycle with the request already driven; returns post-edge in
   // the IDLE cycle after done, with the requester's line dropped.
   task automatic runFill(input string tag, input bit isD, input logic [15:0] base,
                          input int dropAt, input int wrAt);
      bit          issuing, ret, last;
      logic [15:0] expAddr;
      @(negedge clk);
      checkVal({tag, "_idle_en"}, mem_en, 1'b0);
      for (int cyc = 0; cyc < LAT + WORDS; cyc++) begin
         @(posedge clk); #1;
         if (cyc == 1) begin
            if (isD) d_miss_addr = 16'hFFFF;
            else     i_miss_addr = 16'hFFFF;
         end
         if (cyc == dropAt) begin
            if (isD) d_miss_req = 1'b0;
            else     i_miss_req = 1'b0;
         end
         if (cyc == wrAt) begin
            d_wr_addr = 16'h0040;
            d_wr_data = 16'hBEEF;
            d_wr_req  = 1'b1;
         end
         @(negedge clk);
         issuing = (cyc < WORDS);
         ret     = (cyc >= LAT);
         last    = (cyc == LAT + WORDS - 1);
         checkVal({tag, "_mem_en"}, mem_en, issuing);
         if (issuing) begin
            expAddr = base + 16'(2 * cyc);
            checkVal({tag, "_mem_addr"}, mem_addr, expAddr);
            checkVal({tag, "_mem_wr"}, mem_wr, 1'b0);
         end
         checkVal({tag, "_we"}, isD ? d_fill_we : i_fill_we, ret);
         checkVal({tag, "_we_other"}, isD ? i_fill_we : d_fill_we, 1'b0);
         if (ret) begin
            expAddr = (base + 16'(2 * (cyc - LAT))) ^ 16'hA5A5;
            checkVal({tag, "_fill_word"}, fill_word, cyc - LAT);
            checkVal({tag, "_fill_data"}, fill_data, expAddr);
         end
         checkVal({tag, "_done"}, isD ? d_fill_done : i_fill_done, last);
         checkVal({tag, "_done_other"}, isD ? i_fill_done : d_fill_done, 1'b0);
         checkVal({tag, "_i_busy"}, i_busy, i_miss_req && !(last && !isD));
         checkVal({tag, "_d_busy"}, d_busy, (d_miss_req && !(last && isD)) || d_wr_req);
      end
      @(posedge clk); #1;
      if (isD) d_miss_req = 1'b0;
      else     i_miss_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      spur        = 1'b0;
      i_miss_req  = 1'b1;
      d_miss_req  = 1'b0;
      d_wr_req    = 1'b0;
      i_miss_addr = 16'h1234;
      d_miss_addr = '0;
      d_wr_addr   = '0;
      d_wr_data   = '0;

      // Reset: outputs forced low even with a request pending.
      @(negedge clk);
      checkVal("reset_outs", allOuts, 60'd0);
      @(posedge clk); #1;
      i_miss_req = 1'b0;
      rst_n      = 1'b1;

      // Basic I fill from 0x1234: block 0x1230, words 0x1230..0x123E.
      i_miss_addr = 16'h1234;
      i_miss_req  = 1'b1;
      runFill("ifill", 1'b0, 16'h1230, -1, -1);

      // Spurious rvalid while IDLE must not write either cache.
      spur = 1'b1;
      @(negedge clk);
      checkVal("spur_i_we", i_fill_we, 1'b0);
      checkVal("spur_d_we", d_fill_we, 1'b0);
      checkVal("spur_mem_en", mem_en, 1'b0);
      @(posedge clk); #1;
      spur = 1'b0;

      // Write-through beats a D miss raised in the same cycle.
      d_miss_addr = 16'h5A07;
      d_miss_req  = 1'b1;
      d_wr_addr   = 16'h0100;
      d_wr_data   = 16'h1111;
      d_wr_req    = 1'b1;
      @(negedge clk);
      checkVal("prio_idle_en", mem_en, 1'b0);
      checkVal("prio_d_busy", d_busy, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      checkVal("prio_wr", mem_wr, 1'b1);
      checkVal("prio_addr", mem_addr, 16'h0100);
      checkVal("prio_wdata", mem_wdata, 16'h1111);
      checkVal("prio_ack", d_wr_ack, 1'b1);
      @(posedge clk); #1;
      d_wr_req = 1'b0;
      runFill("prio_dfill", 1'b1, 16'h5A00, -1, -1);

      // I and D misses together: D first, I follows after one IDLE cycle, i_busy held throughout.
      d_miss_addr = 16'h2007;
      i_miss_addr = 16'h3456;
      d_miss_req  = 1'b1;
      i_miss_req  = 1'b1;
      runFill("both_d", 1'b1, 16'h2000, -1, -1);
      checkVal("both_i_busy_idle", i_busy, 1'b1);
      i_miss_addr = 16'h3456;
      runFill("both_i", 1'b0, 16'h3450, -1, -1);

      // Write raised during an I fill waits for i_fill_done.
      i_miss_addr = 16'h0102;
      i_miss_req  = 1'b1;
      runFill("wrwait", 1'b0, 16'h0100, -1, 2);
      @(negedge clk);
      checkVal("wrwait_idle_en", mem_en, 1'b0);
      checkVal("wrwait_idle_ack", d_wr_ack, 1'b0);
      checkVal("wrwait_idle_busy", d_busy, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      checkVal("wrwait_en", mem_en, 1'b1);
      checkVal("wrwait_wr", mem_wr, 1'b1);
      checkVal("wrwait_addr", mem_addr, 16'h0040);
      checkVal("wrwait_wdata", mem_wdata, 16'hBEEF);
      checkVal("wrwait_ack", d_wr_ack, 1'b1);
      checkVal("wrwait_busy", d_busy, 1'b0);
      @(posedge clk); #1;
      d_wr_req = 1'b0;
      @(negedge clk);
      checkVal("wrwait_after_en", mem_en, 1'b0);
      checkVal("wrwait_after_ack", d_wr_ack, 1'b0);

      // Reset while fill word 3 is on the bus, then a fresh fill from word 0.
      @(posedge clk); #1;
      i_miss_addr = 16'h1234;
      i_miss_req  = 1'b1;
      for (int cyc = 0; cyc <= LAT + 3; cyc++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      checkVal("rst_pre_we", i_fill_we, 1'b1);
      checkVal("rst_pre_word", fill_word, 3'd3);
      #1 rst_n = 1'b0;
      #1 checkVal("rst_async_outs", allOuts, 60'd0);
      repeat (2) @(posedge clk);
      #1;
      checkVal("rst_hold_outs", allOuts, 60'd0);
      i_miss_addr = 16'h1234;
      rst_n       = 1'b1;
      runFill("refill", 1'b0, 16'h1230, -1, -1);

      // i_miss_req dropped mid-fill: the fill still finishes with done.
      i_miss_addr = 16'h0A00;
      i_miss_req  = 1'b1;
      runFill("drop", 1'b0, 16'h0A00, 3, -1);
      @(negedge clk);
      checkVal("drop_idle_en", mem_en, 1'b0);
      checkVal("drop_idle_busy", i_busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
